// File: rtl/nclic_int_sequencer.sv
// Core-side nCLIC interrupt sequencer: preemption decision, fetch redirect handshake,
// pending-clear write-back, priority nesting stack and mret tail-chaining.
module nclic_int_sequencer #(
    parameter int NoInterrupts = 16,
    parameter int StackDepth   = 4,
    parameter int PrioWidth    = 3,
    localparam int IdxW   = (NoInterrupts > 1) ? $clog2(NoInterrupts) : 1,
    localparam int DepthW = $clog2(StackDepth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_int,
    input  logic [IdxW-1:0]      i_idx,
    input  logic [PrioWidth-1:0] i_prio,
    input  logic                 i_global_ie,
    output logic [IdxW-1:0]      o_vec_idx,
    input  logic [31:0]          i_vector,
    output logic                 o_redirect_valid,
    output logic [31:0]          o_redirect_pc,
    input  logic                 i_redirect_ready,
    input  logic                 i_mret,
    output logic                 o_mret_ack,
    output logic                 o_clr_en,
    output logic [IdxW-1:0]      o_clr_idx,
    output logic [PrioWidth-1:0] o_cur_prio,
    output logic [DepthW-1:0]    o_depth
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_CLEAR
    } state_e;

    typedef enum logic {
        MODE_PUSH,
        MODE_REPLACE
    } mode_e;

    state_e                 state_q;
    mode_e                  mode_q;
    logic [IdxW-1:0]        lat_idx_q;
    logic [PrioWidth-1:0]   lat_prio_q;
    logic [DepthW-1:0]      depth_q;
    logic                   redirect_valid_q;
    logic [31:0]            redirect_pc_q;
    logic                   clr_en_q;
    logic [IdxW-1:0]        clr_idx_q;
    logic                   mret_ack_q;

    logic [IdxW-1:0]        stk_idx_q  [StackDepth];
    logic [PrioWidth-1:0]   stk_prio_q [StackDepth];

    logic [PrioWidth-1:0]   cur_prio;
    logic [PrioWidth-1:0]   below_prio;
    logic [IdxW-1:0]        cur_idx;
    logic                   take_ok;
    logic                   tail_ok;

    // Top and next-below entries are selected by depth rather than by a pointer
    // index so an empty stack reads as thread level (0) without out-of-range access.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cur_prio   = '0;
        below_prio = '0;
        cur_idx    = '0;
        for (int i = 0; i < StackDepth; i++) begin
            if (DepthW'(i + 1) == depth_q) begin
                cur_prio = stk_prio_q[i];
                cur_idx  = stk_idx_q[i];
            end
            if (DepthW'(i + 2) == depth_q) begin
                below_prio = stk_prio_q[i];
            end
        end
    end

    always_comb begin
        take_ok = i_int && i_global_ie && (i_prio > cur_prio)
                  && (depth_q < DepthW'(StackDepth)) && !i_mret;
        tail_ok = i_int && i_global_ie && (i_prio > below_prio);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            mode_q           <= MODE_PUSH;
            lat_idx_q        <= '0;
            lat_prio_q       <= '0;
            depth_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            clr_en_q         <= 1'b0;
            clr_idx_q        <= '0;
            mret_ack_q       <= 1'b0;
            // NOTE: stack storage is cleared for deterministic contents; reads are gated by depth anyway.
            for (int i = 0; i < StackDepth; i++) begin
                stk_idx_q[i]  <= '0;
                stk_prio_q[i] <= '0;
            end
        end else begin
            mret_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_mret && (depth_q != '0)) begin
                        if (tail_ok) begin
                            lat_idx_q        <= i_idx;
                            lat_prio_q       <= i_prio;
                            redirect_pc_q    <= i_vector;
                            redirect_valid_q <= 1'b1;
                            mode_q           <= MODE_REPLACE;
                            state_q          <= ST_REDIRECT;
                        end else begin
                            depth_q    <= depth_q - DepthW'(1);
                            mret_ack_q <= 1'b1;
                        end
                    end else if (take_ok) begin
                        lat_idx_q        <= i_idx;
                        lat_prio_q       <= i_prio;
                        redirect_pc_q    <= i_vector;
                        redirect_valid_q <= 1'b1;
                        mode_q           <= MODE_PUSH;
                        state_q          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ready) begin
                        for (int i = 0; i < StackDepth; i++) begin
                            if ((mode_q == MODE_PUSH && DepthW'(i) == depth_q) ||
                                (mode_q == MODE_REPLACE && DepthW'(i + 1) == depth_q)) begin
                                stk_idx_q[i]  <= lat_idx_q;
                                stk_prio_q[i] <= lat_prio_q;
                            end
                        end
                        if (mode_q == MODE_PUSH) begin
                            depth_q <= depth_q + DepthW'(1);
                        end
                        redirect_valid_q <= 1'b0;
                        clr_en_q         <= 1'b1;
                        clr_idx_q        <= lat_idx_q;
                        state_q          <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The entry just written at accept must be the source being cleared.
    always_ff @(posedge clk) begin
        if (reset && state_q == ST_CLEAR) begin
            assert (cur_idx == clr_idx_q);
        end
    end

    assign o_vec_idx        = i_idx;
    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_mret_ack       = mret_ack_q;
    assign o_clr_en         = clr_en_q;
    assign o_clr_idx        = clr_idx_q;
    assign o_cur_prio       = cur_prio;
    assign o_depth          = depth_q;

endmodule

// File: tb/tb_nclic_int_sequencer.sv
// Self-checking bench for nclic_int_sequencer: scoreboard queues for redirects and
// clears, plus direct checks of nesting level, depth and mret acknowledge.
module tb_nclic_int_sequencer;

    logic        clk;
    logic        reset;
    logic        i_int;
    logic [2:0]  i_idx;
    logic [2:0]  i_prio;
    logic        i_global_ie;
    logic [2:0]  o_vec_idx;
    logic [31:0] i_vector;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_redirect_ready;
    logic        i_mret;
    logic        o_mret_ack;
    logic        o_clr_en;
    logic [2:0]  o_clr_idx;
    logic [2:0]  o_cur_prio;
    logic [1:0]  o_depth;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_redir [$];
    logic [2:0]  exp_clr   [$];

    nclic_int_sequencer #(
        .NoInterrupts(8),
        .StackDepth  (2),
        .PrioWidth   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_int           (i_int),
        .i_idx           (i_idx),
        .i_prio          (i_prio),
        .i_global_ie     (i_global_ie),
        .o_vec_idx       (o_vec_idx),
        .i_vector        (i_vector),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc   (o_redirect_pc),
        .i_redirect_ready(i_redirect_ready),
        .i_mret          (i_mret),
        .o_mret_ack      (o_mret_ack),
        .o_clr_en        (o_clr_en),
        .o_clr_idx       (o_clr_idx),
        .o_cur_prio      (o_cur_prio),
        .o_depth         (o_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   o_redirect_valid, 0);
        check({tag, "_pc"},      o_redirect_pc,    0);
        check({tag, "_clr_en"},  o_clr_en,         0);
        check({tag, "_clr_idx"}, o_clr_idx,        0);
        check({tag, "_ack"},     o_mret_ack,       0);
        check({tag, "_prio"},    o_cur_prio,       0);
        check({tag, "_depth"},   o_depth,          0);
    endtask

    task automatic do_take(input logic [2:0] idx, input logic [2:0] prio,
                           input logic [31:0] vec, input logic [1:0] exp_depth);
        i_int = 1'b1; i_idx = idx; i_prio = prio; i_vector = vec; i_redirect_ready = 1'b1;
        exp_redir.push_back(vec);
        exp_clr.push_back(idx);
        cyc();
        check("take_valid", o_redirect_valid, 1);
        i_int = 1'b0;
        cyc();
        check("take_clr_en", o_clr_en, 1);
        check("take_prio", o_cur_prio, prio);
        check("take_depth", o_depth, exp_depth);
        cyc();
        check("take_clr_done", o_clr_en, 0);
    endtask

    // Scoreboard side: every accepted redirect and every clear must match the queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (o_redirect_valid && i_redirect_ready) begin
                if (exp_redir.size() == 0) check("unexpected_redirect", 1, 0);
                else                       check("redirect_pc", o_redirect_pc, exp_redir.pop_front());
            end
            if (o_clr_en) begin
                if (exp_clr.size() == 0) check("unexpected_clear", 1, 0);
                else                     check("clr_idx", o_clr_idx, exp_clr.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; i_int = 1'b0; i_idx = '0; i_prio = '0; i_global_ie = 1'b0;
        i_vector = '0; i_redirect_ready = 1'b0; i_mret = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        reset = 1'b1;
        cyc();

        // Basic take; the request stays asserted to show the same source is not retaken.
        i_global_ie = 1'b1; i_int = 1'b1; i_idx = 3'd3; i_prio = 3'd2;
        i_vector = 32'h400; i_redirect_ready = 1'b1;
        exp_redir.push_back(32'h400);
        exp_clr.push_back(3'd3);
        cyc();
        check("basic_valid", o_redirect_valid, 1);
        check("basic_pc", o_redirect_pc, 32'h400);
        check("vec_idx", o_vec_idx, 3);
        cyc();
        check("basic_valid_drop", o_redirect_valid, 0);
        check("basic_clr_en", o_clr_en, 1);
        check("basic_prio", o_cur_prio, 2);
        check("basic_depth", o_depth, 1);
        cyc();
        check("basic_clr_done", o_clr_en, 0);
        cyc();
        check("no_retake", o_redirect_valid, 0);

        // Equal priority from another source does not preempt.
        i_idx = 3'd5; i_vector = 32'h500;
        cyc(); cyc();
        check("equal_prio_blocked", o_redirect_valid, 0);
        check("equal_prio_depth", o_depth, 1);

        do_take(3'd7, 3'd5, 32'h700, 2'd2);

        i_mret = 1'b1;
        cyc();
        i_mret = 1'b0;
        check("pop_ack", o_mret_ack, 1);
        check("pop_prio", o_cur_prio, 2);
        check("pop_depth", o_depth, 1);
        cyc();
        check("pop_ack_pulse", o_mret_ack, 0);

        // Tail-chain: lower-priority request still beats thread level below the top.
        i_int = 1'b1; i_idx = 3'd4; i_prio = 3'd1; i_vector = 32'h480; i_mret = 1'b1;
        exp_redir.push_back(32'h480);
        exp_clr.push_back(3'd4);
        cyc();
        i_mret = 1'b0; i_int = 1'b0;
        check("tail_ack", o_mret_ack, 0);
        check("tail_valid", o_redirect_valid, 1);
        check("tail_pc", o_redirect_pc, 32'h480);
        cyc();
        check("tail_clr_en", o_clr_en, 1);
        check("tail_depth", o_depth, 1);
        check("tail_prio", o_cur_prio, 1);
        check("tail_ack2", o_mret_ack, 0);
        cyc();

        // Backpressure with request churn and stray mret pulses while redirecting.
        i_redirect_ready = 1'b0;
        i_int = 1'b1; i_idx = 3'd6; i_prio = 3'd6; i_vector = 32'h600;
        exp_redir.push_back(32'h600);
        exp_clr.push_back(3'd6);
        cyc();
        i_idx = 3'd2; i_prio = 3'd7; i_vector = 32'h200;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", o_redirect_valid, 1);
            check("bp_pc", o_redirect_pc, 32'h600);
            check("bp_clr", o_clr_en, 0);
            check("bp_ack", o_mret_ack, 0);
            i_mret = i[0];
            cyc();
        end
        i_mret = 1'b0; i_int = 1'b0; i_redirect_ready = 1'b1;
        cyc();
        check("bp_clr_en", o_clr_en, 1);
        check("bp_depth", o_depth, 2);
        check("bp_prio", o_cur_prio, 6);
        cyc();
        check("bp_clr_done", o_clr_en, 0);
        check("bp_valid_done", o_redirect_valid, 0);

        // Full stack: a higher priority cannot be pushed.
        i_int = 1'b1; i_idx = 3'd1; i_prio = 3'd7; i_vector = 32'h100;
        cyc(); cyc(); cyc();
        check("full_blocked", o_redirect_valid, 0);
        check("full_depth", o_depth, 2);
        i_int = 1'b0;

        // Drain the stack.
        i_mret = 1'b1;
        cyc();
        i_mret = 1'b0;
        check("drain1_ack", o_mret_ack, 1);
        check("drain1_prio", o_cur_prio, 1);
        cyc();
        i_mret = 1'b1;
        cyc();
        i_mret = 1'b0;
        check("drain2_ack", o_mret_ack, 1);
        check("drain2_prio", o_cur_prio, 0);
        check("drain2_depth", o_depth, 0);
        cyc();

        // Stray mret at thread level.
        i_mret = 1'b1;
        cyc();
        i_mret = 1'b0;
        check("stray_ack", o_mret_ack, 0);
        check("stray_depth", o_depth, 0);

        // Global interrupt enable masks takes.
        i_global_ie = 1'b0; i_int = 1'b1; i_idx = 3'd2; i_prio = 3'd4; i_vector = 32'h240;
        cyc(); cyc();
        check("masked_valid", o_redirect_valid, 0);
        check("masked_depth", o_depth, 0);

        // Reset while a redirect is pending: abandoned, no clear follows.
        i_global_ie = 1'b1; i_idx = 3'd5; i_prio = 3'd3; i_vector = 32'h5a0; i_redirect_ready = 1'b0;
        cyc();
        check("rst_pending_valid", o_redirect_valid, 1);
        reset = 1'b0;
        cyc();
        check_all_zero("midreset");
        i_int = 1'b0; i_redirect_ready = 1'b1; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_reset_no_clr", o_clr_en, 0);
        end

        check("redir_queue_empty", exp_redir.size(), 0);
        check("clr_queue_empty", exp_clr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
